// File: rtl/bucket_drain_ctrl.sv
// Drains a range of bucket sets from bucket memory onto an AXI-Stream, one coordinate per beat.
// Reads are credit-limited against the internal FIFO so no memory return is ever dropped.
//
// state | meaning
// IDLE  | waiting for start_i
// ISSUE | issuing bucket reads while credit is available
// DRAIN | all reads issued, emptying latency pipe and FIFO
// DONE  | one-cycle completion pulse
module bucket_drain_ctrl #(
  parameter int P_DATA_PNT_W = 377,
  parameter int P_NUM_WIN    = 7,
  parameter int P_BKT_ADDR_W = 15,
  parameter int P_NUM_COORD  = 4,
  parameter int P_BM_LAT     = 9,
  parameter int P_FIFO_DEPTH = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start_i,
  input  logic [$clog2(P_NUM_WIN)-1:0]          win_first_i,
  input  logic [$clog2(P_NUM_WIN)-1:0]          win_last_i,
  input  logic                                  clear_en_i,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic                                  err_o,
  output logic                                  bm_rd_en_o,
  output logic [$clog2(P_NUM_WIN)-1:0]          bm_bucket_set_addr_o,
  output logic [P_BKT_ADDR_W-1:0]               bm_bucket_addr_o,
  output logic                                  bm_clear_bucket_o,
  input  logic [P_NUM_COORD*P_DATA_PNT_W-1:0]   bm_bucket_val_i,
  output logic [P_DATA_PNT_W-1:0]               bw_data_o,
  output logic [$clog2(P_NUM_WIN)-1:0]          bw_user_o,
  output logic                                  bw_valid_o,
  output logic                                  bw_last_o,
  input  logic                                  bw_ready_i
);
  localparam int WW = $clog2(P_NUM_WIN);
  localparam int AW = WW + P_BKT_ADDR_W;
  localparam int BW = P_NUM_COORD * P_DATA_PNT_W;
  localparam int PW = $clog2(P_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int KW = $clog2(P_NUM_COORD);
  localparam logic [KW-1:0] LAST_K = KW'(P_NUM_COORD - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]          state;
  logic [AW-1:0]       addr;
  logic [WW-1:0]       win_last_q;
  logic                clear_en_q;
  logic                err_q;
  logic [CW-1:0]       credit;
  logic [P_BM_LAT-1:0] pipe_v;
  logic [P_BM_LAT-1:0] pipe_last;
  logic [WW-1:0]       pipe_set [P_BM_LAT];
  logic [BW-1:0]       fifo_data [P_FIFO_DEPTH];
  logic [WW-1:0]       fifo_set [P_FIFO_DEPTH];
  logic [P_FIFO_DEPTH-1:0] fifo_last;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       fifo_cnt;
  logic [KW-1:0]       coord;

  logic          range_ok;
  logic          at_last_addr;
  logic          issue;
  logic          fifo_wr;
  logic          accept;
  logic          pop;
  logic [BW-1:0] head_data;

  assign range_ok     = (win_first_i <= win_last_i) && (32'(win_last_i) < P_NUM_WIN);
  assign at_last_addr = (addr == {win_last_q, {P_BKT_ADDR_W{1'b1}}});
  assign issue        = (state == S_ISSUE) && (credit != '0);
  assign fifo_wr      = pipe_v[P_BM_LAT-1];
  assign head_data    = fifo_data[rd_ptr];

  assign bw_valid_o = (fifo_cnt != '0);
  assign accept     = bw_valid_o && bw_ready_i;
  assign pop        = accept && (coord == LAST_K);
  // Data and user are zeroed when idle so every output reads 0 out of reset.
  assign bw_data_o  = bw_valid_o ? head_data[coord*P_DATA_PNT_W +: P_DATA_PNT_W] : '0;
  assign bw_user_o  = bw_valid_o ? fifo_set[rd_ptr] : '0;
  assign bw_last_o  = bw_valid_o && fifo_last[rd_ptr] && (coord == LAST_K);

  assign bm_rd_en_o           = issue;
  assign bm_clear_bucket_o    = issue && clear_en_q;
  assign bm_bucket_set_addr_o = addr[AW-1 -: WW];
  assign bm_bucket_addr_o     = addr[P_BKT_ADDR_W-1:0];

  assign busy_o = (state == S_ISSUE) || (state == S_DRAIN);
  assign done_o = (state == S_DONE);
  assign err_o  = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      addr       <= '0;
      win_last_q <= '0;
      clear_en_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            if (range_ok) begin
              addr       <= {win_first_i, {P_BKT_ADDR_W{1'b0}}};
              win_last_q <= win_last_i;
              clear_en_q <= clear_en_i;
              state      <= S_ISSUE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (issue) begin
            if (at_last_addr) state <= S_DRAIN;
            else addr <= addr + AW'(1);
          end
        end
        S_DRAIN: begin
          if (pop && bw_last_o && (pipe_v == '0)) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Credit covers reads in flight plus FIFO occupancy, returned when a bucket pops.
  always_ff @(posedge clk) begin
    if (rst) credit <= CW'(P_FIFO_DEPTH);
    else if (issue && !pop) credit <= credit - CW'(1);
    else if (pop && !issue) credit <= credit + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= issue;
      for (int i = 1; i < P_BM_LAT; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_set[0]  <= bm_bucket_set_addr_o;
    pipe_last[0] <= at_last_addr;
    for (int i = 1; i < P_BM_LAT; i++) begin
      pipe_set[i]  <= pipe_set[i-1];
      pipe_last[i] <= pipe_last[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_data[wr_ptr] <= bm_bucket_val_i;
      fifo_set[wr_ptr]  <= pipe_set[P_BM_LAT-1];
      fifo_last[wr_ptr] <= pipe_last[P_BM_LAT-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      coord    <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (fifo_wr && !pop) fifo_cnt <= fifo_cnt + CW'(1);
      else if (pop && !fifo_wr) fifo_cnt <= fifo_cnt - CW'(1);
      if (accept) coord <= (coord == LAST_K) ? '0 : coord + KW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(fifo_wr && (fifo_cnt == CW'(P_FIFO_DEPTH))));
  end

endmodule

// File: tb/tb_bucket_drain_ctrl.sv
// Directed bench for bucket_drain_ctrl: instance A (4 coords, deep FIFO) and instance B
// (3 coords, 2-entry FIFO), each fed by a small latency-accurate bucket memory model.
module tb_bucket_drain_ctrl;
  localparam int LAT = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  logic        a_start = 1'b0, a_clr = 1'b0, a_ready = 1'b1;
  logic [2:0]  a_wf = '0, a_wl = '0;
  logic        a_busy, a_done, a_err, a_rd, a_clrb, a_valid, a_last;
  logic [2:0]  a_set, a_addr, a_user;
  logic [63:0] a_val;
  logic [15:0] a_data;
  logic [31:0] a_outs;

  logic        b_start = 1'b0, b_ready = 1'b0;
  logic [2:0]  b_wf = '0, b_wl = '0;
  logic        b_busy, b_done, b_err, b_rd, b_clrb, b_valid, b_last;
  logic [2:0]  b_set, b_addr, b_user;
  logic [47:0] b_val;
  logic [15:0] b_data;
  logic [31:0] b_outs;

  assign a_outs = {a_busy, a_done, a_err, a_rd, a_clrb, a_valid, a_last, a_set, a_addr, a_user, a_data};
  assign b_outs = {b_busy, b_done, b_err, b_rd, b_clrb, b_valid, b_last, b_set, b_addr, b_user, b_data};

  bucket_drain_ctrl #(
    .P_DATA_PNT_W(16), .P_NUM_WIN(7), .P_BKT_ADDR_W(3),
    .P_NUM_COORD(4), .P_BM_LAT(LAT), .P_FIFO_DEPTH(16)
  ) u_dut_a (
    .clk(clk), .rst(rst), .start_i(a_start), .win_first_i(a_wf), .win_last_i(a_wl),
    .clear_en_i(a_clr), .busy_o(a_busy), .done_o(a_done), .err_o(a_err),
    .bm_rd_en_o(a_rd), .bm_bucket_set_addr_o(a_set), .bm_bucket_addr_o(a_addr),
    .bm_clear_bucket_o(a_clrb), .bm_bucket_val_i(a_val), .bw_data_o(a_data),
    .bw_user_o(a_user), .bw_valid_o(a_valid), .bw_last_o(a_last), .bw_ready_i(a_ready)
  );

  bucket_drain_ctrl #(
    .P_DATA_PNT_W(16), .P_NUM_WIN(7), .P_BKT_ADDR_W(3),
    .P_NUM_COORD(3), .P_BM_LAT(LAT), .P_FIFO_DEPTH(2)
  ) u_dut_b (
    .clk(clk), .rst(rst), .start_i(b_start), .win_first_i(b_wf), .win_last_i(b_wl),
    .clear_en_i(1'b0), .busy_o(b_busy), .done_o(b_done), .err_o(b_err),
    .bm_rd_en_o(b_rd), .bm_bucket_set_addr_o(b_set), .bm_bucket_addr_o(b_addr),
    .bm_clear_bucket_o(b_clrb), .bm_bucket_val_i(b_val), .bw_data_o(b_data),
    .bw_user_o(b_user), .bw_valid_o(b_valid), .bw_last_o(b_last), .bw_ready_i(b_ready)
  );

  // Coordinate k of bucket (s,b); the identity point is (0,1,0,...).
  function automatic logic [15:0] pat(int s, int b, int k);
    return {4'(s), 4'(b), 4'(k), 4'h5};
  endfunction

  function automatic logic [63:0] word_a(logic [2:0] s, logic [2:0] b, logic cleared);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) w[k*16 +: 16] = cleared ? ((k == 1) ? 16'd1 : 16'd0) : pat(s, b, k);
    return w;
  endfunction

  function automatic logic [47:0] word_b(logic [2:0] s, logic [2:0] b);
    logic [47:0] w;
    w = '0;
    for (int k = 0; k < 3; k++) w[k*16 +: 16] = pat(s, b, k);
    return w;
  endfunction

  logic [63:0] a_cleared = '0;
  logic [63:0] ma_pipe [LAT];
  logic [47:0] mb_pipe [LAT];

  // Bucket memory: read-then-clear, data valid LAT cycles after the read strobe.
  always @(posedge clk) begin
    ma_pipe[0] <= word_a(a_set, a_addr, a_cleared[{a_set, a_addr}]);
    mb_pipe[0] <= word_b(b_set, b_addr);
    for (int i = 1; i < LAT; i++) begin
      ma_pipe[i] <= ma_pipe[i-1];
      mb_pipe[i] <= mb_pipe[i-1];
    end
    if (a_rd && a_clrb) a_cleared[{a_set, a_addr}] <= 1'b1;
  end
  assign a_val = ma_pipe[LAT-1];
  assign b_val = mb_pipe[LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drain_a(input int wf, input int wl, input logic clr, input logic ident,
                         input int restart_at, input string tag);
    int nb, nrd, ncyc, r0, v0, gaps, nexp, bkt, s, b, k, spur;
    logic [15:0] ed;
    bit fin;
    nexp = (wl - wf + 1) * 32;
    nb = 0; nrd = 0; ncyc = 0; r0 = -1; v0 = -1; gaps = 0; spur = 0; fin = 0;
    @(posedge clk); #1;
    a_wf = 3'(wf); a_wl = 3'(wl); a_clr = clr; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    while (!fin && ncyc < 3000) begin
      @(negedge clk);
      ncyc++;
      if (ncyc == 1) chk({tag, "_busy"}, 64'(a_busy), 64'd1);
      if (ncyc == restart_at) begin
        a_wf = 3'd0; a_wl = 3'd6; a_start = 1'b1;
      end else begin
        a_start = 1'b0;
      end
      if (a_rd) begin
        if (r0 < 0) r0 = ncyc;
        chk({tag, "_rd_addr"}, 64'({a_set, a_addr}), 64'(wf * 8 + nrd));
        chk({tag, "_rd_clr"}, 64'(a_clrb), 64'(clr));
        nrd++;
      end
      if (a_valid) begin
        if (v0 < 0) v0 = ncyc;
        bkt = nb / 4; s = wf + bkt / 8; b = bkt % 8; k = nb % 4;
        ed = ident ? ((k == 1) ? 16'd1 : 16'd0) : pat(s, b, k);
        chk({tag, "_data"}, 64'(a_data), 64'(ed));
        chk({tag, "_user"}, 64'(a_user), 64'(s));
        chk({tag, "_last"}, 64'(a_last), 64'(nb == nexp - 1));
        nb++;
        if (nb == nexp) begin
          @(negedge clk);
          chk({tag, "_done"}, 64'(a_done), 64'd1);
          chk({tag, "_busy_at_done"}, 64'(a_busy), 64'd0);
          @(negedge clk);
          chk({tag, "_done_1cyc"}, 64'(a_done), 64'd0);
          fin = 1;
        end
      end else if (v0 >= 0) begin
        gaps++;
      end
      if (!fin && a_done) spur++;
    end
    a_start = 1'b0;
    chk({tag, "_finished"}, 64'(fin), 64'd1);
    chk({tag, "_reads"}, 64'(nrd), 64'(nexp / 4));
    chk({tag, "_beats"}, 64'(nb), 64'(nexp));
    chk({tag, "_gaps"}, 64'(gaps), 64'd0);
    chk({tag, "_first_lat"}, 64'(v0 - r0), 64'(LAT + 1));
    chk({tag, "_early_done"}, 64'(spur), 64'd0);
  endtask

  task automatic drain_b(input int wf, input int wl, input int stall, input int pct, input string tag);
    int nb, nrd, ncyc, nexp, bkt, s, b, k, hold_bad, maxo;
    logic pv, prdy, pl;
    logic [15:0] pd;
    logic [2:0] pu;
    bit fin;
    nexp = (wl - wf + 1) * 24;
    nb = 0; nrd = 0; ncyc = 0; hold_bad = 0; maxo = 0; fin = 0;
    pv = 1'b0; prdy = 1'b0; pl = 1'b0; pd = '0; pu = '0;
    @(posedge clk); #1;
    b_wf = 3'(wf); b_wl = 3'(wl); b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    while (!fin && ncyc < 3000) begin
      @(negedge clk);
      ncyc++;
      b_ready = (ncyc <= stall) ? 1'b0 : ($urandom_range(99, 0) < pct);
      if (pv && !prdy && (!b_valid || b_data != pd || b_user != pu || b_last != pl)) hold_bad++;
      pv = b_valid; prdy = b_ready; pd = b_data; pu = b_user; pl = b_last;
      if (b_rd) begin
        chk({tag, "_rd_addr"}, 64'({b_set, b_addr}), 64'(wf * 8 + nrd));
        nrd++;
      end
      if (ncyc == stall) chk({tag, "_stall_reads"}, 64'(nrd), 64'd2);
      if (nrd - nb / 3 > maxo) maxo = nrd - nb / 3;
      if (b_valid && b_ready) begin
        bkt = nb / 3; s = wf + bkt / 8; b = bkt % 8; k = nb % 3;
        chk({tag, "_data"}, 64'(b_data), 64'(pat(s, b, k)));
        chk({tag, "_user"}, 64'(b_user), 64'(s));
        chk({tag, "_last"}, 64'(b_last), 64'(nb == nexp - 1));
        nb++;
        if (nb == nexp) begin
          @(negedge clk);
          chk({tag, "_done"}, 64'(b_done), 64'd1);
          fin = 1;
        end
      end
    end
    b_ready = 1'b0;
    chk({tag, "_finished"}, 64'(fin), 64'd1);
    chk({tag, "_reads"}, 64'(nrd), 64'(nexp / 3));
    chk({tag, "_beats"}, 64'(nb), 64'(nexp));
    chk({tag, "_hold"}, 64'(hold_bad), 64'd0);
    chk({tag, "_credit_bound"}, 64'(maxo > 2), 64'd0);
  endtask

  task automatic bad_range(input int wf, input int wl, input string tag);
    int errs, act;
    @(posedge clk); #1;
    a_wf = 3'(wf); a_wl = 3'(wl); a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    @(negedge clk);
    chk({tag, "_err"}, 64'(a_err), 64'd1);
    chk({tag, "_busy"}, 64'(a_busy), 64'd0);
    errs = 0; act = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_err) errs++;
      if (a_rd || a_busy || a_valid) act++;
    end
    chk({tag, "_err_once"}, 64'(errs), 64'd0);
    chk({tag, "_no_activity"}, 64'(act), 64'd0);
  endtask

  initial begin
    int n, cyc, stale;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_a_outs", 64'(a_outs), 64'd0);
    chk("reset_b_outs", 64'(b_outs), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_a_outs", 64'(a_outs), 64'd0);

    drain_a(0, 0, 1'b0, 1'b0, 0, "single_set");
    drain_a(2, 3, 1'b1, 1'b0, 6, "clear_2_3");
    drain_a(2, 3, 1'b0, 1'b1, 0, "reread_2_3");
    bad_range(4, 2, "bad_order");
    bad_range(0, 7, "bad_last");

    // abandon a drain with reads in flight
    @(posedge clk); #1;
    a_wf = 3'd1; a_wl = 3'd1; a_clr = 1'b0; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    n = 0; cyc = 0;
    while (n < 3 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (a_rd) n++;
    end
    chk("rst_reads_before", 64'(n), 64'd3);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_outs", 64'(a_outs), 64'd0);
    rst = 1'b0;
    stale = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_valid || a_rd || a_done || a_busy) stale++;
    end
    chk("rst_no_stale", 64'(stale), 64'd0);
    drain_a(1, 1, 1'b0, 1'b0, 0, "after_rst");

    drain_b(0, 0, 100, 100, "stall");
    drain_b(1, 2, 0, 30, "rand");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
